// File: rtl/legv8_pkg.sv
// Shared LEGv8 datapath definitions: PC operation codes, status bit positions
// and small address helpers used by the fetch stage.
package legv8_pkg;

    // PC operation selected by the control word's PS field.
    typedef enum logic [1:0] {
        PS_HOLD = 2'b00,
        PS_INC  = 2'b01,
        PS_REG  = 2'b10,
        PS_REL  = 2'b11
    } ps_e;

    // Bit positions inside the 5-bit status vector.
    localparam int ST_V    = 4;
    localparam int ST_C    = 3;
    localparam int ST_N    = 2;
    localparam int ST_Z    = 1;
    localparam int ST_ZRAW = 0;

    // Instructions are one 32-bit word each.
    localparam logic [63:0] INSN_BYTES = 64'd4;

    // Register-indirect targets are forced onto a word boundary.
    function automatic logic [63:0] align_word(input logic [63:0] addr);
        return addr & ~64'h3;
    endfunction

    // Word offset to byte offset; bits shifted past bit 63 are dropped.
    function automatic logic [63:0] word_to_byte(input logic [63:0] words);
        return words << 2;
    endfunction

endpackage

// File: rtl/RegisterNbit.sv
// Generic N-bit register with synchronous reset and load enable.
module RegisterNbit #(
    parameter int           N         = 64,
    parameter logic [N-1:0] RESET_VAL = '0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] q_q;
    logic [N-1:0] q_d;

    // Hold unless load is asserted.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = d;
        end
    end

    // Reset wins over load.
    always_ff @(posedge clock) begin
        if (reset) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Increment on enable, but stick at all-ones instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (enable && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Clear has priority over counting.
    always_ff @(posedge clock) begin
        if (clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: program counter, instruction register, status flags and
// debug retire/branch counters feeding the LEGv8 control unit.
import legv8_pkg::*;

module fetch_pc_unit #(
    parameter logic [63:0] RESET_VECTOR = 64'h0,
    parameter int          CNT_W        = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       PS,
    input  logic             PCsel,
    input  logic             IL,
    input  logic             SL,
    input  logic [63:0]      constant,
    input  logic [63:0]      reg_a,
    input  logic [3:0]       alu_vcnz,
    output logic [63:0]      imem_addr,
    input  logic [31:0]      imem_data,
    output logic [63:0]      PC,
    output logic [63:0]      pc_plus4,
    output logic [31:0]      I,
    output logic [4:0]       status,
    output logic             pc_fault,
    output logic [CNT_W-1:0] retired,
    output logic [CNT_W-1:0] taken
);

    logic [63:0]        pc_q;
    logic [63:0]        instr_addr_q;
    logic [31:0]        ir_q;
    logic [63:0]        next_pc;
    logic [63:0]        rel_offset;
    logic [ST_V:ST_Z]   flags_q;
    logic [ST_V:ST_Z]   flags_d;
    logic               pc_fault_q;
    logic               pc_fault_d;
    logic               is_taken;
    logic               misaligned;

    // Relative branches are measured from the instruction in I, not from PC,
    // because PC has already moved on by the time the branch is decoded.
    always_comb begin
        rel_offset = 64'd0;
        if (PCsel) begin
            rel_offset = word_to_byte(constant);
        end
    end

    // Next-PC selection by PS.
    always_comb begin
        next_pc = pc_q;
        unique case (ps_e'(PS))
            PS_HOLD: next_pc = pc_q;
            PS_INC:  next_pc = pc_q + INSN_BYTES;
            PS_REG:  next_pc = align_word(reg_a);
            PS_REL:  next_pc = instr_addr_q + rel_offset;
            default: next_pc = pc_q;
        endcase
    end

    // The ROM has a registered read, so it is addressed with the PC that will
    // be current after this edge; its word then arrives together with the PC.
    // During reset it is pinned to the reset vector so the first fetch is valid.
    assign imem_addr = reset ? RESET_VECTOR : next_pc;

    RegisterNbit #(
        .N         (64),
        .RESET_VAL (RESET_VECTOR)
    ) u_pc_reg (
        .clock (clock),
        .reset (reset),
        .load  (1'b1),
        .d     (next_pc),
        .q     (pc_q)
    );

    RegisterNbit #(
        .N         (32),
        .RESET_VAL (32'h0)
    ) u_ir_reg (
        .clock (clock),
        .reset (reset),
        .load  (IL),
        .d     (imem_data),
        .q     (ir_q)
    );

    RegisterNbit #(
        .N         (64),
        .RESET_VAL (64'h0)
    ) u_instr_addr_reg (
        .clock (clock),
        .reset (reset),
        .load  (IL),
        .d     (pc_q),
        .q     (instr_addr_q)
    );

    // Latched flags V,C,N,Z take the ALU flags one bit each when SL is high.
    genvar gi;
    generate
        for (gi = ST_Z; gi <= ST_V; gi++) begin : g_flag
            assign flags_d[gi] = SL ? alu_vcnz[gi-1] : flags_q[gi];
        end
    endgenerate

    // A register-indirect target with low bits set is a software bug; the
    // flag stays up until reset so it can be inspected after the fact.
    assign misaligned = (PS == PS_REG) && (reg_a[1:0] != 2'b00);

    // Sticky fault accumulation.
    always_comb begin
        pc_fault_d = pc_fault_q | misaligned;
    end

    // Status flag and fault registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            flags_q    <= '0;
            pc_fault_q <= 1'b0;
        end else begin
            flags_q    <= flags_d;
            pc_fault_q <= pc_fault_d;
        end
    end

    assign is_taken = (PS == PS_REG) || (PS == PS_REL);

    sat_counter #(
        .W (CNT_W)
    ) u_retired_cnt (
        .clock  (clock),
        .clear  (reset),
        .enable (IL),
        .count  (retired)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_taken_cnt (
        .clock  (clock),
        .clear  (reset),
        .enable (is_taken),
        .count  (taken)
    );

    assign PC       = pc_q;
    assign I        = ir_q;
    assign pc_plus4 = instr_addr_q + INSN_BYTES;
    assign pc_fault = pc_fault_q;

    // Live Z bypasses the latch so CBZ/CBNZ can use this cycle's ALU result.
    assign status[ST_V:ST_Z] = flags_q;
    assign status[ST_ZRAW]   = alu_vcnz[0];

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Randomised bench for fetch_pc_unit against a behavioural model of the
// fetch stage, with directed scenarios for the notable corner cases.
module tb_fetch_pc_unit;

    localparam logic [63:0] RV    = 64'h100;
    localparam int          CW    = 4;
    localparam int          CMAX  = (1 << CW) - 1;

    logic          clock;
    logic          reset;
    logic [1:0]    PS;
    logic          PCsel;
    logic          IL;
    logic          SL;
    logic [63:0]   constant;
    logic [63:0]   reg_a;
    logic [3:0]    alu_vcnz;
    logic [63:0]   imem_addr;
    logic [31:0]   imem_data;
    logic [63:0]   PC;
    logic [63:0]   pc_plus4;
    logic [31:0]   I;
    logic [4:0]    status;
    logic          pc_fault;
    logic [CW-1:0] retired;
    logic [CW-1:0] taken;

    fetch_pc_unit #(
        .RESET_VECTOR (RV),
        .CNT_W        (CW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .PS        (PS),
        .PCsel     (PCsel),
        .IL        (IL),
        .SL        (SL),
        .constant  (constant),
        .reg_a     (reg_a),
        .alu_vcnz  (alu_vcnz),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .PC        (PC),
        .pc_plus4  (pc_plus4),
        .I         (I),
        .status    (status),
        .pc_fault  (pc_fault),
        .retired   (retired),
        .taken     (taken)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Contents of the instruction ROM: a distinct word per address.
    function automatic logic [31:0] rom_word(input logic [63:0] a);
        return a[33:2] ^ a[63:32] ^ 32'hC0DE_0000;
    endfunction

    // Synchronous ROM: word for the presented address one edge later.
    always @(posedge clock) imem_data <= rom_word(imem_addr);

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference state: what the fetch stage should hold.
    logic [63:0] m_pc;
    logic [63:0] m_ia;
    logic [31:0] m_i;
    logic [3:0]  m_st;
    logic        m_f;
    int          m_r;
    int          m_t;
    logic        m_valid = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic set_in(input logic rst, input logic [1:0] ps, input logic pcsel,
                          input logic il, input logic sl, input logic [63:0] cst,
                          input logic [63:0] ra, input logic [3:0] vcnz);
        reset    = rst;
        PS       = ps;
        PCsel    = pcsel;
        IL       = il;
        SL       = sl;
        constant = cst;
        reg_a    = ra;
        alu_vcnz = vcnz;
    endtask

    // One clock: predict from the spec's rules, check before and after the edge.
    task automatic step();
        logic [63:0] n_pc, n_ia;
        logic [31:0] n_i;
        logic [3:0]  n_st;
        logic        n_f;
        int          n_r, n_t;
        #2;
        n_pc = m_pc; n_ia = m_ia; n_i = m_i; n_st = m_st; n_f = m_f; n_r = m_r; n_t = m_t;
        if (reset) begin
            n_pc = RV; n_ia = 0; n_i = 0; n_st = 0; n_f = 0; n_r = 0; n_t = 0;
        end else begin
            if (PS == 2'd0) n_pc = m_pc;
            else if (PS == 2'd1) n_pc = m_pc + 64'd4;
            else if (PS == 2'd2) n_pc = reg_a - (reg_a % 64'd4);
            else n_pc = m_ia + (PCsel ? constant * 64'd4 : 64'd0);
            if (IL) begin
                n_i  = rom_word(m_pc);
                n_ia = m_pc;
            end
            if (SL) n_st = alu_vcnz;
            if (PS == 2'd2 && (reg_a % 64'd4) != 0) n_f = 1'b1;
            if (IL) n_r = (m_r == CMAX) ? CMAX : m_r + 1;
            if (PS >= 2'd2) n_t = (m_t == CMAX) ? CMAX : m_t + 1;
        end
        chk("z_live", {63'd0, status[0]}, {63'd0, alu_vcnz[0]});
        if (reset) chk("imem_addr_rst", imem_addr, RV);
        else if (m_valid) chk("imem_addr", imem_addr, n_pc);
        if (m_valid) begin
            chk("pc_plus4", pc_plus4, m_ia + 64'd4);
            chk("status_hi", {60'd0, status[4:1]}, {60'd0, m_st});
        end
        @(posedge clock);
        #1;
        cyc++;
        m_pc = n_pc; m_ia = n_ia; m_i = n_i; m_st = n_st; m_f = n_f; m_r = n_r; m_t = n_t;
        m_valid = m_valid | reset;
        if (m_valid) begin
            chk("pc", PC, m_pc);
            chk("ir", {32'd0, I}, {32'd0, m_i});
            chk("pc_fault", {63'd0, pc_fault}, {63'd0, m_f});
            chk("retired", {60'd0, retired}, 64'(m_r));
            chk("taken", {60'd0, taken}, 64'(m_t));
        end
        $display("cyc %0d rst=%0b ps=%0d il=%0b sl=%0b pc=%h I=%h ret=%0d tkn=%0d",
                 cyc, reset, PS, IL, SL, PC, I, retired, taken);
    endtask

    initial begin
        logic [63:0] cst;
        set_in(1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 64'd7, 64'd3, 4'hF);
        step();
        step();
        chk("rst_pc", PC, RV);
        chk("rst_pp4", pc_plus4, 64'd4);
        chk("rst_ir", {32'd0, I}, 64'd0);

        // Three fetch cycles from the reset vector.
        set_in(1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 64'd0, 64'd0, 4'h0);
        step(); chk("fetch1_pc", PC, 64'h104); chk("fetch1_ir", {32'd0, I}, {32'd0, rom_word(64'h100)});
        step(); chk("fetch2_pc", PC, 64'h108); chk("fetch2_ir", {32'd0, I}, {32'd0, rom_word(64'h104)});
        step(); chk("fetch3_pc", PC, 64'h10C); chk("fetch3_ir", {32'd0, I}, {32'd0, rom_word(64'h108)});
        chk("fetch_ret", {60'd0, retired}, 64'd3);

        // Backward relative branch from instr_addr 0x200.
        set_in(1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 64'd0, 64'h200, 4'h0); step();
        set_in(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 64'd0, 64'd0, 4'h0);   step();
        chk("br_ia", pc_plus4, 64'h204);
        set_in(1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 4'h0); step();
        chk("br_pc", PC, 64'h1F8);
        chk("br_taken", {60'd0, taken}, 64'd2);

        // Misaligned register target.
        set_in(1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 64'd0, 64'h3007, 4'h0); step();
        chk("mis_pc", PC, 64'h3004);
        chk("mis_fault", {63'd0, pc_fault}, 64'd1);
        set_in(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 4'h0);
        for (int i = 0; i < 10; i++) step();
        chk("mis_sticky", {63'd0, pc_fault}, 64'd1);

        // Latched flags plus live Z.
        set_in(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 64'd0, 64'd0, 4'b1010); step();
        set_in(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 4'b0001);
        #1;
        chk("status_mix", {59'd0, status}, 64'b10101);
        step();

        // Offset overflow from instr_addr 0.
        set_in(1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 4'h0); step();
        set_in(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 64'd0, 64'd0, 4'h0); step();
        set_in(1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 64'h4000_0000_0000_0001, 64'd0, 4'h0); step();
        chk("ovf_pc", PC, 64'h4);

        // Reset in a branch cycle.
        set_in(1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 64'd5, 64'd0, 4'hF); step();
        chk("rstbr_pc", PC, RV);
        chk("rstbr_taken", {60'd0, taken}, 64'd0);
        chk("rstbr_ir", {32'd0, I}, 64'd0);

        // Randomised traffic, including counter saturation and stray resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 0)
                cst = 64'($urandom_range(0, 64)) - 64'd32;
            else
                cst = {$urandom, $urandom};
            set_in($urandom_range(0, 39) == 0, 2'($urandom_range(0, 3)), 1'($urandom),
                   1'($urandom), 1'($urandom), cst, {$urandom, $urandom}, 4'($urandom));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
